// File: rtl/sram_like_ram_pkg.sv
// Shared encodings and bounds for the SRAM-like responder and its storage.
package sram_like_ram_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned STRB_W      = DATA_W / 8;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 15;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Response attributes captured at the accepting edge.
    typedef struct packed {
        logic rd;
        logic err;
    } resp_t;

endpackage

// File: rtl/sram_like_ram_byte_en_ram.sv
// Word-wide storage with per-byte write enables and a registered read port.
module byte_en_ram
    import sram_like_ram_pkg::*;
#(
    parameter int unsigned DEPTH_WIDTH = 10
) (
    input  logic                   clk,
    input  logic [STRB_W-1:0]      we_i,
    input  logic                   re_i,
    input  logic [DEPTH_WIDTH-1:0] addr_i,
    input  logic [DATA_W-1:0]      wdata_i,
    output logic [DATA_W-1:0]      rdata_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_WIDTH;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read output only moves on a read, so it holds the sampled word while the response is pending.
    always_ff @(posedge clk) begin
        for (int b = 0; b < int'(STRB_W); b++) begin
            if (we_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_like_ram.sv
// SRAM-like protocol responder: one outstanding request, fixed response latency,
// byte/half/word accesses with misalignment errors.
module sram_like_ram
    import sram_like_ram_pkg::*;
#(
    parameter int unsigned DEPTH_WIDTH = 10,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic        err
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    resp_t             resp_q, resp_d;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic [STRB_W-1:0] strb_c;
    logic              bad_c;
    logic              accept_c;
    logic [STRB_W-1:0] we_c;
    logic              re_c;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] resp_data_c;
    logic              unused_addr_c;

    assign unused_addr_c = ^addr[31:DEPTH_WIDTH+2];

    // Lane strobe and alignment decode.
    always_comb begin
        strb_c = '0;
        bad_c  = 1'b0;
        unique case (size_e'(size))
            SIZE_BYTE: strb_c = 4'b0001 << addr[1:0];
            SIZE_HALF: begin
                strb_c = 4'b0011 << {addr[1], 1'b0};
                bad_c  = addr[0];
            end
            SIZE_WORD: begin
                strb_c = 4'b1111;
                bad_c  = |addr[1:0];
            end
            default:   bad_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A new acceptance takes priority, which lets it overlap the previous data_ok cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (accept_c) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
        end else if (state_q == ST_WAIT) begin
            if (cnt_q == '0) begin
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        data_ok  = (state_q == ST_WAIT) && (cnt_q == '0);
        addr_ok  = req && ((state_q == ST_IDLE) || data_ok);
        accept_c = addr_ok;
    end

    assign we_c      = (accept_c && wr && !bad_c) ? strb_c : '0;
    assign re_c      = accept_c && !wr && !bad_c;
    assign resp_d.rd  = !wr && !bad_c;
    assign resp_d.err = bad_c;

    byte_en_ram #(
        .DEPTH_WIDTH(DEPTH_WIDTH)
    ) u_ram (
        .clk    (clk),
        .we_i   (we_c),
        .re_i   (re_c),
        .addr_i (addr[DEPTH_WIDTH+1:2]),
        .wdata_i(wdata),
        .rdata_o(ram_rdata)
    );

    assign resp_data_c = resp_q.rd ? ram_rdata : '0;

    // Response attributes and the held copy of the last response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept_c) begin
                resp_q <= resp_d;
            end
            if (data_ok) begin
                rdata_q <= resp_data_c;
                err_q   <= resp_q.err;
            end
        end
    end

    assign rdata = data_ok ? resp_data_c : rdata_q;
    assign err   = data_ok ? resp_q.err  : err_q;

endmodule
